// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder: synchronise, debounce and priority-encode a 20-key pad into a keycode with a press strobe
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   in_i     : raw key levels, 1 = pressed (bits 0-15 digits, 16-19 commands)
//   out_o    : keycode of the last accepted press (highest set bit wins)
//   strobe_o : one-cycle pulse when a new keycode is valid
//   held_o   : high while a key is accepted and not yet debounced-released
//   KEYPAD_AUTO_REPEAT_EN : when defined, a held key re-strobes after REPEAT_DELAY, then every REPEAT_PERIOD
module keypad_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] in_i,
  output logic [4:0]  out_o,
  output logic        strobe_o,
  output logic        held_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t state_q, state_d;
  logic [19:0] sync_q, s_q, cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0] out_q, out_d;
  logic strobe_q, strobe_d, rep_hit;
  function automatic logic [4:0] enc(input logic [19:0] v);
    enc = '0;
    for (int i = 0; i < 20; i++) if (v[i]) enc = 5'(i);
  endfunction
  assign cnt_inc = (cnt_q == DMAX) ? cnt_q : cnt_q + 1'b1;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RDP = RW'(REPEAT_DELAY + REPEAT_PERIOD);
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  logic hold_tick;
  assign hold_tick = (state_q == HELD) && (s_q != '0);
  assign rpt_inc = rpt_q + 1'b1;
  assign rep_hit = hold_tick && (rpt_inc == RD || rpt_inc == RDP);
  // The count freezes in DEB_REL so a bounce back to HELD resumes the cadence.
  assign rpt_d = hold_tick ? ((rpt_inc == RDP) ? RD : rpt_inc) : (state_q == DEB_REL || state_q == HELD) ? rpt_q : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rpt_q <= '0;
    else rpt_q <= rpt_d;
`else
  assign rep_hit = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    out_d = out_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: if (s_q != '0) begin
        cand_d = s_q;
        cnt_d = ONE;
        state_d = (ONE == DMAX) ? HELD : DEB_PRESS;
        out_d = (ONE == DMAX) ? enc(s_q) : out_q;
        strobe_d = (ONE == DMAX);
      end
      DEB_PRESS: if (s_q == '0) state_d = IDLE;
      else if (s_q != cand_q) begin
        cand_d = s_q;
        cnt_d = ONE;
      end else begin
        cnt_d = cnt_inc;
        state_d = (cnt_inc == DMAX) ? HELD : DEB_PRESS;
        out_d = (cnt_inc == DMAX) ? enc(cand_q) : out_q;
        strobe_d = (cnt_inc == DMAX);
      end
      HELD: if (s_q == '0) begin
        cnt_d = ONE;
        state_d = (ONE == DMAX) ? IDLE : DEB_REL;
      end else strobe_d = rep_hit;
      DEB_REL: if (s_q != '0) state_d = HELD;
      else begin
        cnt_d = cnt_inc;
        state_d = (cnt_inc == DMAX) ? IDLE : DEB_REL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      s_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= in_i;
      s_q <= sync_q;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      strobe_q <= strobe_d;
    end
  assign out_o = out_q;
  assign strobe_o = strobe_q;
  assign held_o = (state_q == HELD) || (state_q == DEB_REL);
endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// tb_keypad_debounce_encoder: directed self-checking bench for keypad_debounce_encoder
module tb_keypad_debounce_encoder;
  logic clk = 1'b0;
  logic rst_n;
  logic [19:0] in_i;
  logic [4:0] out_o;
  logic strobe_o, held_o;
  int errs = 0;
  int checks = 0;
  keypad_debounce_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_i(in_i),
    .out_o(out_o), .strobe_o(strobe_o), .held_o(held_o)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    logic rep_exp;
    rst_n = 1'b0;
    in_i = '0;
    #1;
    check("rst_out", out_o, 0);
    check("rst_strobe", strobe_o, 0);
    check("rst_held", held_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check("t1_out", out_o, 0);
      check("t1_strobe", strobe_o, 0);
      check("t1_held", held_o, 0);
    end
    in_i = 20'h00020;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("t2_strobe", strobe_o, e == 6);
      check("t2_held", held_o, e >= 6);
      if (e >= 6) check("t2_out", out_o, 5);
    end
    in_i = '0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("t2_rel_held", held_o, e < 6);
      check("t2_rel_strobe", strobe_o, 0);
      check("t2_rel_out", out_o, 5);
    end
    in_i = 20'h00008;
    tick();
    tick();
    in_i = '0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("t3_strobe", strobe_o, 0);
      check("t3_held", held_o, 0);
      check("t3_out", out_o, 5);
    end
    in_i = 20'h10004;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("t4_strobe", strobe_o, e == 6);
      check("t4_held", held_o, e >= 6);
      if (e >= 6) check("t4_out", out_o, 16);
    end
    in_i = 20'h90004;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("t4_add_strobe", strobe_o, 0);
      check("t4_add_out", out_o, 16);
      check("t4_add_held", held_o, 1);
    end
    in_i = '0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("t4_rel_held", held_o, e < 6);
      check("t4_rel_strobe", strobe_o, 0);
    end
    in_i = 20'h00080;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("t5_strobe", strobe_o, e == 6);
      if (e >= 6) check("t5_out", out_o, 7);
    end
    for (int e = 0; e < 6; e++) begin
      in_i = e[0] ? 20'h00080 : 20'h0;
      tick();
      check("t5_bounce_held", held_o, 1);
      check("t5_bounce_strobe", strobe_o, 0);
    end
    in_i = '0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("t5_rel_held", held_o, e < 6);
      check("t5_rel_strobe", strobe_o, 0);
      check("t5_rel_out", out_o, 7);
    end
    in_i = 20'h00400;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", out_o, 0);
    check("t6_rst_held", held_o, 0);
    check("t6_rst_strobe", strobe_o, 0);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      tick();
`ifdef KEYPAD_AUTO_REPEAT_EN
      rep_exp = (e == 6 || e == 56 || e == 66 || e == 76);
`else
      rep_exp = (e == 6);
`endif
      check("t6_strobe", strobe_o, rep_exp);
      check("t6_held", held_o, e >= 6);
      check("t6_out", out_o, (e >= 6) ? 10 : 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
